register_file_32x32: RTL and testbench



---
 rtl/register_file_32x32_if.sv | 26 ++
 rtl/register_file_32x32.sv | 105 ++++++++++
 tb/tb_register_file_32x32.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/register_file_32x32_if.sv
// Register-file bus bundle: two read ports, one write port and the read-valid flag.
// The master drives requests; the slave returns registered read data.
interface register_file_32x32_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr_r1;
    logic [ADDR_WIDTH-1:0] addr_r2;
    logic [ADDR_WIDTH-1:0] addr_w;
    logic [DATA_WIDTH-1:0] data_w;
    logic [DATA_WIDTH-1:0] data_r1;
    logic [DATA_WIDTH-1:0] data_r2;
    logic                  rd_valid;

    modport master (
        output read, write, addr_r1, addr_r2, addr_w, data_w,
        input  data_r1, data_r2, rd_valid
    );

    modport slave (
        input  read, write, addr_r1, addr_r2, addr_w, data_w,
        output data_r1, data_r2, rd_valid
    );
endinterface

// File: rtl/register_file_32x32.sv
// 32x32 register file: two registered read ports, one write port,
// write-first bypass and a hardwired-zero R0.
//
// state | meaning
// IDLE  | no read accepted at the last edge, rd_valid low
// VALID | read accepted at the last edge, rd_valid high
module register_file_32x32 (
    input  logic                  clk,
    input  logic                  rst,
    register_file_32x32_if.slave  bus
);
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic [DEPTH-1:0]      write_en;
    logic [DATA_WIDTH-1:0] entry [1:DEPTH-1];
    logic [DATA_WIDTH-1:0] read_next1;
    logic [DATA_WIDTH-1:0] read_next2;
    logic [DATA_WIDTH-1:0] data_r1;
    logic [DATA_WIDTH-1:0] data_r2;
    logic                  bypass1;
    logic                  bypass2;
    logic                  write_live;

    // Address 0 never enables a flop, which is what makes R0 read as zero.
    always_comb begin
        write_en = '0;
        for (int i = 1; i < DEPTH; i++) begin
            write_en[i] = bus.write && (bus.addr_w == ADDR_WIDTH'(i));
        end
    end

    for (genvar g = 1; g < DEPTH; g++) begin : g_entry
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                entry[g] <= '0;
            end else if (write_en[g]) begin
                entry[g] <= bus.data_w;
            end
        end
    end

    assign write_live = bus.write && (bus.addr_w != '0);
    assign bypass1    = write_live && (bus.addr_r1 == bus.addr_w);
    assign bypass2    = write_live && (bus.addr_r2 == bus.addr_w);

    always_comb begin
        read_next1 = '0;
        read_next2 = '0;
        for (int i = 1; i < DEPTH; i++) begin
            if (bus.addr_r1 == ADDR_WIDTH'(i)) begin
                read_next1 = entry[i];
            end
            if (bus.addr_r2 == ADDR_WIDTH'(i)) begin
                read_next2 = entry[i];
            end
        end
        if (bypass1) begin
            read_next1 = bus.data_w;
        end
        if (bypass2) begin
            read_next2 = bus.data_w;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r1 <= '0;
            data_r2 <= '0;
        end else if (bus.read) begin
            data_r1 <= read_next1;
            data_r2 <= read_next2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.read)  state_next = VALID;
            VALID:   if (!bus.read) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.data_r1  = data_r1;
    assign bus.data_r2  = data_r2;
    assign bus.rd_valid = (state == VALID);
endmodule

// File: tb/tb_register_file_32x32.sv
// Directed, table-driven bench for register_file_32x32 with hand-written
// reset sequences around the table.
module tb_register_file_32x32;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    register_file_32x32_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    register_file_32x32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [4:0]  aw;
        logic [31:0] dw;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ev;
    } vec_t;

    vec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] e1, input logic [31:0] e2,
                              input logic ev);
        check({tag, " data_r1"}, bus.data_r1, e1);
        check({tag, " data_r2"}, bus.data_r2, e2);
        check({tag, " rd_valid"}, {31'b0, bus.rd_valid}, {31'b0, ev});
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] aw, input logic [31:0] dw);
        bus.read    = rd;
        bus.write   = wr;
        bus.addr_r1 = a1;
        bus.addr_r2 = a2;
        bus.addr_w  = aw;
        bus.data_w  = dw;
    endtask

    task automatic step(input logic rd, input logic wr, input logic [4:0] a1,
                        input logic [4:0] a2, input logic [4:0] aw, input logic [31:0] dw);
        @(negedge clk);
        drive(rd, wr, a1, a2, aw, dw);
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic rd, input logic wr, input logic [4:0] a1,
                                input logic [4:0] a2, input logic [4:0] aw, input logic [31:0] dw,
                                input logic [31:0] e1, input logic [31:0] e2, input logic ev);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a1 = a1; v.a2 = a2; v.aw = aw; v.dw = dw;
        v.e1 = e1; v.e2 = e2; v.ev = ev;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [4:0] pair;
        checks = 0;
        errors = 0;

        // Table: write/read all, R0, bypass, hold/valid. Starts with outputs at 0,0.
        for (int i = 1; i < 32; i++) begin
            add(1'b0, 1'b1, 5'd0, 5'd0, 5'(i), 32'h100 + 32'(i), 32'h0, 32'h0, 1'b0);
        end
        for (int i = 1; i < 32; i++) begin
            pair = 5'(32 - i);
            add(1'b1, 1'b0, 5'(i), pair, 5'd0, 32'h0,
                32'h100 + 32'(i), 32'h100 + 32'(pair), 1'b1);
        end
        add(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b1);
        add(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        add(1'b1, 1'b0, 5'd0, 5'd5, 5'd0, 32'h0, 32'h0, 32'h105, 1'b1);
        add(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h1111_1111, 32'h0, 32'h105, 1'b0);
        add(1'b1, 1'b0, 5'd7, 5'd0, 5'd0, 32'h0, 32'h1111_1111, 32'h0, 1'b1);
        add(1'b1, 1'b1, 5'd7, 5'd7, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b1);
        add(1'b1, 1'b1, 5'd3, 5'd9, 5'd9, 32'hCAFE_F00D, 32'h103, 32'hCAFE_F00D, 1'b1);
        add(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234, 32'h0, 32'h0, 1'b1);
        add(1'b1, 1'b0, 5'd7, 5'd9, 5'd0, 32'h0, 32'hA5A5_A5A5, 32'hCAFE_F00D, 1'b1);
        add(1'b0, 1'b1, 5'd0, 5'd0, 5'd10, 32'h1234_5678, 32'hA5A5_A5A5, 32'hCAFE_F00D, 1'b0);
        add(1'b1, 1'b0, 5'd10, 5'd10, 5'd0, 32'h0, 32'h1234_5678, 32'h1234_5678, 1'b1);
        add(1'b0, 1'b1, 5'd10, 5'd10, 5'd10, 32'h1, 32'h1234_5678, 32'h1234_5678, 1'b0);
        add(1'b0, 1'b1, 5'd10, 5'd10, 5'd10, 32'h2, 32'h1234_5678, 32'h1234_5678, 1'b0);
        add(1'b0, 1'b1, 5'd10, 5'd10, 5'd10, 32'h3, 32'h1234_5678, 32'h1234_5678, 1'b0);
        add(1'b1, 1'b0, 5'd10, 5'd0, 5'd0, 32'h0, 32'h3, 32'h0, 1'b1);
        add(1'b1, 1'b0, 5'd10, 5'd11, 5'd0, 32'h0, 32'h3, 32'h10B, 1'b1);

        // Power-on reset
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        rst = 1'b1;
        #12;
        check_outs("por", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset clear
        step(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEAD_BEEF);
        step(1'b1, 1'b0, 5'd5, 5'd5, 5'd0, 32'h0);
        check_outs("r5 before reset", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        rst = 1'b1;
        #2;
        rst = 1'b0;
        step(1'b1, 1'b0, 5'd5, 5'd31, 5'd0, 32'h0);
        check_outs("reset clear", 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
        check_outs("idle after read", 32'h0, 32'h0, 1'b0);

        foreach (tbl[k]) begin
            step(tbl[k].rd, tbl[k].wr, tbl[k].a1, tbl[k].a2, tbl[k].aw, tbl[k].dw);
            check_outs($sformatf("vec%0d", k), tbl[k].e1, tbl[k].e2, tbl[k].ev);
        end

        // Async reset between edges while outputs are nonzero; a write under reset is dropped
        step(1'b1, 1'b0, 5'd10, 5'd11, 5'd0, 32'h0);
        check_outs("pre async", 32'h3, 32'h10B, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async reset", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd12, 5'd12, 5'd12, 32'h0000_0077);
        @(posedge clk);
        #1;
        check_outs("under reset", 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 1'b0, 5'd12, 5'd10, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check_outs("after reset", 32'h0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 5'd12, 5'd12, 5'd12, 32'h0000_0088);
        check_outs("first op after reset", 32'h88, 32'h88, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
